usr_shift_engine: RTL and testbench

Parametrised successor to the 4-bit universal shift register: a WIDTH-bit universal shift register driven by a command interface. A command is start + op + count. The block performs `count` single-bit shift/rotate steps, one per clock, reporting progress with busy and a one-cycle done. It sits where the fixed-mode register used to be, and lets control logic issue multi-position shifts without sequencing the mode lines every cycle.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_step.sv | 32 +++
 rtl/usr_shift_engine.sv | 99 +++++++++
 tb/tb_usr_shift_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared opcodes, FSM states and opcode classification for the universal shift engine.
// USR_ROTATE_EN: when defined, ROR/ROL are real multi-step ops; otherwise they act as NOP.
package usr_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Ops that honour count and step once per clock; everything else is one-shot.
  function automatic logic is_multi(input logic [2:0] op);
    logic m;
    m = 1'b0;
    case (op)
      OP_SHR, OP_SHL, OP_ASR: m = 1'b1;
`ifdef USR_ROTATE_EN
      OP_ROR, OP_ROL:         m = 1'b1;
`endif
      default:                m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step datapath: next register value for one opcode application.
// USR_ROTATE_EN: builds the ROR/ROL paths; without it those opcodes leave the value unchanged.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (op)
      OP_SHR:  nxt = {sir, cur[WIDTH-1:1]};
      OP_SHL:  nxt = {cur[WIDTH-2:0], sil};
      OP_LOAD: nxt = load_data;
`ifdef USR_ROTATE_EN
      OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
      OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  nxt = '0;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/usr_shift_engine.sv
// Command-driven WIDTH-bit universal shift register: start+op+count runs count steps, one per clock.
// USR_ROTATE_EN: enables ROR/ROL; when undefined they complete as one-cycle NOPs.
module usr_shift_engine
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] I,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] O,
  output logic             SOR,
  output logic             SOL,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       op_q;
  logic [CW-1:0]    remaining;
  logic [WIDTH-1:0] o_q;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_nxt;

  // In IDLE the step acts on the live opcode so the first step lands on the accept edge.
  assign step_op = (state == ST_RUN) ? op_q : op;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op       (step_op),
    .cur      (o_q),
    .load_data(I),
    .sil      (SIL),
    .sir      (SIR),
    .nxt      (step_nxt)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      remaining <= '0;
      o_q       <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= op;
            if (is_multi(op) && (count != '0)) begin
              o_q       <= step_nxt;
              remaining <= count - CW'(1);
              if (count == CW'(1)) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
              end
            end else begin
              // One-shot ops apply here; a zero-count shift leaves O untouched.
              if (!is_multi(op)) o_q <= step_nxt;
              remaining <= '0;
              state     <= ST_DONE;
              done      <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          o_q       <= step_nxt;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O    = o_q;
  assign SOR  = o_q[0];
  assign SOL  = o_q[WIDTH-1];
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_usr_shift_engine.sv
// Self-checking bench for usr_shift_engine (WIDTH=4, CW=4): directed table, corner sequences, random commands.
// Expectations for ROR/ROL follow USR_ROTATE_EN as seen by this compilation.
module tb_usr_shift_engine;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [2:0] op;
  logic [3:0] count;
  logic [3:0] I;
  logic       SIL;
  logic       SIR;
  logic [3:0] O;
  logic       SOR;
  logic       SOL;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] modelO = 4'b0000;

`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  usr_shift_engine #(.WIDTH(4), .CW(4)) dut (
    .clk  (clk),
    .clear(clear),
    .start(start),
    .op   (op),
    .count(count),
    .I    (I),
    .SIL  (SIL),
    .SIR  (SIR),
    .O    (O),
    .SOR  (SOR),
    .SOL  (SOL),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] preO;
    logic [2:0] vop;
    logic [3:0] vcnt;
    logic [3:0] vdata;
    logic       vsil;
    logic       vsir;
    logic [3:0] expO;
    int         expBusy;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [3:0] c,
                               input logic [3:0] d, input logic sl, input logic sr);
    start = s;
    op    = o;
    count = c;
    I     = d;
    SIL   = sl;
    SIR   = sr;
  endtask

  // Reference step written as plain integer arithmetic on a 4-bit value.
  function automatic logic [3:0] refStep(input logic [2:0] o, input logic [3:0] v,
                                         input logic sl, input logic sr);
    int x;
    int r;
    x = int'(v);
    case (o)
      3'd1:    r = (x / 2) + (sr ? 8 : 0);
      3'd2:    r = ((x * 2) % 16) + (sl ? 1 : 0);
      3'd4:    r = ROT_EN ? ((x / 2) + (x % 2) * 8) : x;
      3'd5:    r = ROT_EN ? (((x * 2) % 16) + (x / 8)) : x;
      3'd6:    r = (x / 2) + ((x >= 8) ? 8 : 0);
      3'd7:    r = 0;
      default: r = x;
    endcase
    return r[3:0];
  endfunction

  function automatic bit isMultiRef(input logic [2:0] o);
    return (o == 3'd1) || (o == 3'd2) || (o == 3'd6) || (ROT_EN && ((o == 3'd4) || (o == 3'd5)));
  endfunction

  // Issues one command and checks O/SOR/SOL/busy/done every busy cycle against the model.
  task automatic runCommand(input string tag, input logic [2:0] c_op, input logic [3:0] c_cnt,
                            input logic [3:0] c_data, input logic c_sil, input logic c_sir,
                            input bit noisy, output logic [3:0] finalO, output int busyN);
    logic [3:0] m;
    int nb;
    bit multi;
    m     = modelO;
    multi = isMultiRef(c_op);
    nb    = (multi && c_cnt != 0) ? int'(c_cnt) : 1;
    @(negedge clk);
    applyStimulus(1'b1, c_op, c_cnt, c_data, c_sil, c_sir);
    @(negedge clk);
    if (noisy) applyStimulus(1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), c_sil, c_sir);
    else start = 1'b0;
    busyN = 0;
    for (int g = 0; g < 40; g++) begin
      if (!busy) break;
      busyN++;
      if (busyN == 1) begin
        if (c_op == 3'd3) m = c_data;
        else if (c_op == 3'd7) m = 4'b0000;
        else if (multi && c_cnt != 0) m = refStep(c_op, m, c_sil, c_sir);
      end else if (busyN <= nb) begin
        m = refStep(c_op, m, c_sil, c_sir);
      end
      checkOutput({tag, " O"}, int'(O), int'(m));
      checkOutput({tag, " SOR"}, int'(SOR), int'(m[0]));
      checkOutput({tag, " SOL"}, int'(SOL), int'(m[3]));
      checkOutput({tag, " done"}, int'(done), (busyN == nb) ? 1 : 0);
      @(negedge clk);
      if (noisy) applyStimulus(1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), c_sil, c_sir);
      else start = 1'b0;
    end
    start = 1'b0;
    checkOutput({tag, " busy cycles"}, busyN, nb);
    checkOutput({tag, " idle O"}, int'(O), int'(m));
    checkOutput({tag, " idle done"}, int'(done), 0);
    modelO = m;
    finalO = O;
  endtask

  initial begin
    logic [3:0] fo;
    int bn;
    int doneSeen;

    tbl[0]  = '{4'b0000, 3'd3, 4'd0,  4'b1001, 1'b0, 1'b0, 4'b1001, 1};
    tbl[1]  = '{4'b1001, 3'd1, 4'd3,  4'b0000, 1'b0, 1'b1, 4'b1111, 3};
    tbl[2]  = '{4'b1101, 3'd5, 4'd5,  4'b0000, 1'b0, 1'b0, ROT_EN ? 4'b1011 : 4'b1101, ROT_EN ? 5 : 1};
    tbl[3]  = '{4'b1000, 3'd6, 4'd2,  4'b0000, 1'b0, 1'b0, 4'b1110, 2};
    tbl[4]  = '{4'b1011, 3'd2, 4'd4,  4'b0000, 1'b0, 1'b0, 4'b0000, 4};
    tbl[5]  = '{4'b0110, 3'd2, 4'd0,  4'b0000, 1'b1, 1'b1, 4'b0110, 1};
    tbl[6]  = '{4'b0101, 3'd1, 4'd15, 4'b0000, 1'b1, 1'b0, 4'b0000, 15};
    tbl[7]  = '{4'b0110, 3'd4, 4'd9,  4'b0000, 1'b0, 1'b0, ROT_EN ? 4'b0011 : 4'b0110, ROT_EN ? 9 : 1};
    tbl[8]  = '{4'b1010, 3'd7, 4'd7,  4'b0000, 1'b0, 1'b0, 4'b0000, 1};
    tbl[9]  = '{4'b1010, 3'd0, 4'd5,  4'b1111, 1'b0, 1'b0, 4'b1010, 1};
    tbl[10] = '{4'b0001, 3'd2, 4'd15, 4'b0000, 1'b1, 1'b0, 4'b1111, 15};
    tbl[11] = '{4'b0111, 3'd6, 4'd12, 4'b0000, 1'b0, 1'b1, 4'b0000, 12};

    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    checkOutput("reset O", int'(O), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    modelO = 4'b0000;

    $display("[TB] directed table");
    for (int k = 0; k < 12; k++) begin
      runCommand("preload", 3'd3, 4'd0, tbl[k].preO, 1'b0, 1'b0, 1'b0, fo, bn);
      runCommand("table", tbl[k].vop, tbl[k].vcnt, tbl[k].vdata, tbl[k].vsil, tbl[k].vsir, 1'b0, fo, bn);
      checkOutput("table final O", int'(fo), int'(tbl[k].expO));
      checkOutput("table busy", bn, tbl[k].expBusy);
    end

    $display("[TB] ignored start and clear abort");
    runCommand("preload", 3'd3, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, fo, bn);
    doneSeen = 0;
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 4'd6, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("abort run1 O", int'(O), 4'b1000);
    applyStimulus(1'b1, 3'd2, 4'd3, 4'b0101, 1'b0, 1'b1);
    @(negedge clk);
    if (done) doneSeen++;
    checkOutput("ignored start O", int'(O), 4'b1100);
    checkOutput("ignored start busy", int'(busy), 1);
    start = 1'b0;
    @(negedge clk);
    if (done) doneSeen++;
    checkOutput("abort run3 O", int'(O), 4'b1110);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("abort O", int'(O), 0);
    checkOutput("abort busy", int'(busy), 0);
    for (int c = 0; c < 8; c++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abort done never", doneSeen, 0);
    modelO = 4'b0000;

    $display("[TB] start during done cycle");
    @(negedge clk);
    applyStimulus(1'b1, 3'd3, 4'd0, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("done cycle flag", int'(done), 1);
    applyStimulus(1'b1, 3'd3, 4'd0, 4'b1010, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("done-cycle start ignored O", int'(O), 4'b0101);
    checkOutput("done-cycle start ignored busy", int'(busy), 0);
    applyStimulus(1'b1, 3'd3, 4'd0, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("back-to-back accept O", int'(O), 4'b0011);
    checkOutput("back-to-back accept busy", int'(busy), 1);
    @(negedge clk);
    modelO = 4'b0011;

    $display("[TB] random commands");
    for (int r = 0; r < 120; r++) begin
      runCommand("random", 3'($urandom), 4'($urandom_range(0, 15)), 4'($urandom),
                 1'($urandom), 1'($urandom), 1'b1, fo, bn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
